jt51_slot_regs: RTL and testbench
=================================

// Module: jt51_slot_regs
// PURPOSE
// - Per-slot parameter store for the YM2151 (OPM) FM core: 32 slots (4 operators x 8 channels).
// - Sits behind the memory-mapped register decoder, which supplies update strobes, slot address and data byte.
// - Free-running slot counter (advances on cen) selects which slot's parameters drive the outputs.
// - Operator pipeline consumes one slot per cen.
// PARAMETERS
// - none
// PORTS
// clk        in   1  system clock
// rst        in   1  reset (synchronous, active-high)
// cen        in   1  clock enable; slot counter advances only when high
// din        in   8  data byte for the asserted update strobe(s)
// up_rl, up_kc, up_kf, up_pms  in 1 each  channel-register write strobes (use ch)
// up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l  in 1 each  operator-register write strobes (use op, ch)
// up_keyon   in   1  key-on write strobe (uses din only)
// op         in   2  target operator for operator writes: 0=M1, 1=M2, 2=C1, 3=C2
// ch         in   3  target channel
// csm        in   1  CSM key-on request
// overflow_A in   1  timer A overflow
// cycles     out  5  current slot counter
// cur_op     out  2  cycles[4:3]
// cur_ch     out  3  cycles[2:0]
// zero       out  1  high when cycles==0
// half       out  1  high when cycles[3:0]==0
// rl/fb/con  out  2/3/3  channel params of cur_ch
// kc/kf/pms/ams  out  7/6/3/2  channel params of cur_ch
// dt1/mul/tl/ks/ar  out  3/4/7/2/5  operator params of slot cycles
// amsen/d1r/dt2/d2r/d1l/rr  out  1/5/2/5/4/4  operator params of slot cycles
// keyon      out  1  key-on state of slot cycles
// BEHAVIOUR
// - Reset: all storage = 0, cycles = 0, CSM flag = 0.
//   Outputs after reset: all parameters 0, keyon=0, zero=1, half=1. Strobes during reset are ignored.
// - Slot counter: on clk with cen=1, cycles <= cycles+1. Wraps 31->0. Holds when cen=0.
// - Slot index = {op,ch}. Operator arrays have 32 entries; channel arrays have 8 entries.
// - Writes take effect on the clk edge where the strobe is high, regardless of cen.
//   The new value is visible on the outputs the following cycle whenever the addressed slot is current.
// - Field mapping by strobe:
//   - up_rl: rl=din[7:6], fb=din[5:3], con=din[2:0]
//   - up_kc: kc=din[6:0]
//   - up_kf: kf=din[7:2]
//   - up_pms: pms=din[6:4], ams=din[1:0]
//   - up_dt1: dt1=din[6:4], mul=din[3:0]
//   - up_tl: tl=din[6:0]
//   - up_ks: ks=din[7:6], ar=din[4:0]
//   - up_amsen: amsen=din[7], d1r=din[4:0]
//   - up_dt2: dt2=din[7:6], d2r=din[4:0]
//   - up_d1l: d1l=din[7:4], rr=din[3:0]
// - up_keyon: target channel = din[2:0]. Key bits written:
//   - M1 = din[3], C1 = din[4], M2 = din[5], C2 = din[6].
//   - All four operator bits of that channel are overwritten.
// - Simultaneous strobes all apply independently in the same cycle.
// - Parameter outputs are combinational reads of the current slot (zero latency from cycles).
// - CSM: csm && overflow_A on a cen cycle sets the CSM flag. While the flag is set, keyon=1 for every slot.
//   The flag clears on the next cen cycle where cycles==31, i.e. after one full round.
//   Stored key bits are not modified by CSM.
// CONFIGURATION
// - JT51_CSM_EN defined: CSM logic as described above.
// - JT51_CSM_EN undefined: csm and overflow_A are ignored, no CSM flag exists, and keyon = stored bit only.
// TESTING
// - Reset, then 40 cen pulses -> cycles counts 0..31,0..7. zero high at 0; half high at 0 and 16. All params read 0.
// - up_tl, op=2, ch=5, din=0x7F, then step to cycles=21 -> tl=0x7F. tl=0 at every other slot.
// - up_keyon, din=0x7B -> keyon=1 at slots 3, 11, 19, 27 only.
//   Then din=0x03 -> keyon=0 at all slots.
// - up_rl, ch=2, din=0xD5 -> rl=3, fb=2, con=5 at slots 2, 10, 18, 26.
// - With JT51_CSM_EN: csm=1 and overflow_A=1 for one cen at cycles=0 -> keyon=1 for all slots through cycles=31, then stored values resume.
// - Hold cen=0 for 10 clks -> cycles unchanged. A write in that window still lands.

Source files
------------

// File: rtl/jt51_slot_regs.sv
// YM2151 per-slot parameter store: 32 operator slots and 8 channels, read out for the slot chosen by a free-running counter.
// Latency: writes land on the strobe edge; reads are combinational from cycles. No backpressure: strobes are always accepted.
// Optional CSM key-on forcing is built when JT51_CSM_EN is defined.
module jt51_slot_regs (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [7:0] din,
  input  logic       up_rl,
  input  logic       up_kc,
  input  logic       up_kf,
  input  logic       up_pms,
  input  logic       up_dt1,
  input  logic       up_tl,
  input  logic       up_ks,
  input  logic       up_amsen,
  input  logic       up_dt2,
  input  logic       up_d1l,
  input  logic       up_keyon,
  input  logic [1:0] op,
  input  logic [2:0] ch,
  input  logic       csm,
  input  logic       overflow_A,
  output logic [4:0] cycles,
  output logic [1:0] cur_op,
  output logic [2:0] cur_ch,
  output logic       zero,
  output logic       half,
  output logic [1:0] rl,
  output logic [2:0] fb,
  output logic [2:0] con,
  output logic [6:0] kc,
  output logic [5:0] kf,
  output logic [2:0] pms,
  output logic [1:0] ams,
  output logic [2:0] dt1,
  output logic [3:0] mul,
  output logic [6:0] tl,
  output logic [1:0] ks,
  output logic [4:0] ar,
  output logic       amsen,
  output logic [4:0] d1r,
  output logic [1:0] dt2,
  output logic [4:0] d2r,
  output logic [3:0] d1l,
  output logic [3:0] rr,
  output logic       keyon
);

  logic [1:0] rl_r  [0:7];
  logic [2:0] fb_r  [0:7];
  logic [2:0] con_r [0:7];
  logic [6:0] kc_r  [0:7];
  logic [5:0] kf_r  [0:7];
  logic [2:0] pms_r [0:7];
  logic [1:0] ams_r [0:7];

  logic [2:0] dt1_r   [0:31];
  logic [3:0] mul_r   [0:31];
  logic [6:0] tl_r    [0:31];
  logic [1:0] ks_r    [0:31];
  logic [4:0] ar_r    [0:31];
  logic       amsen_r [0:31];
  logic [4:0] d1r_r   [0:31];
  logic [1:0] dt2_r   [0:31];
  logic [4:0] d2r_r   [0:31];
  logic [3:0] d1l_r   [0:31];
  logic [3:0] rr_r    [0:31];
  logic       key_r   [0:31];

  logic [4:0] wslot;
  assign wslot = {op, ch};

  always_ff @(posedge clk) begin
    if (rst) cycles <= 5'd0;
    else if (cen) cycles <= cycles + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        rl_r[i]  <= '0;
        fb_r[i]  <= '0;
        con_r[i] <= '0;
        kc_r[i]  <= '0;
        kf_r[i]  <= '0;
        pms_r[i] <= '0;
        ams_r[i] <= '0;
      end
      for (int i = 0; i < 32; i++) begin
        dt1_r[i]   <= '0;
        mul_r[i]   <= '0;
        tl_r[i]    <= '0;
        ks_r[i]    <= '0;
        ar_r[i]    <= '0;
        amsen_r[i] <= 1'b0;
        d1r_r[i]   <= '0;
        dt2_r[i]   <= '0;
        d2r_r[i]   <= '0;
        d1l_r[i]   <= '0;
        rr_r[i]    <= '0;
        key_r[i]   <= 1'b0;
      end
    end else begin
      if (up_rl) begin
        rl_r[ch]  <= din[7:6];
        fb_r[ch]  <= din[5:3];
        con_r[ch] <= din[2:0];
      end
      if (up_kc) kc_r[ch] <= din[6:0];
      if (up_kf) kf_r[ch] <= din[7:2];
      if (up_pms) begin
        pms_r[ch] <= din[6:4];
        ams_r[ch] <= din[1:0];
      end
      if (up_dt1) begin
        dt1_r[wslot] <= din[6:4];
        mul_r[wslot] <= din[3:0];
      end
      if (up_tl) tl_r[wslot] <= din[6:0];
      if (up_ks) begin
        ks_r[wslot] <= din[7:6];
        ar_r[wslot] <= din[4:0];
      end
      if (up_amsen) begin
        amsen_r[wslot] <= din[7];
        d1r_r[wslot]   <= din[4:0];
      end
      if (up_dt2) begin
        dt2_r[wslot] <= din[7:6];
        d2r_r[wslot] <= din[4:0];
      end
      if (up_d1l) begin
        d1l_r[wslot] <= din[7:4];
        rr_r[wslot]  <= din[3:0];
      end
      // Key-on byte orders operators M1,C1,M2,C2 while slot index orders M1,M2,C1,C2
      if (up_keyon) begin
        key_r[{2'd0, din[2:0]}] <= din[3];
        key_r[{2'd2, din[2:0]}] <= din[4];
        key_r[{2'd1, din[2:0]}] <= din[5];
        key_r[{2'd3, din[2:0]}] <= din[6];
      end
    end
  end

`ifdef JT51_CSM_EN
  logic csm_flag;

  always_ff @(posedge clk) begin
    if (rst) csm_flag <= 1'b0;
    else if (cen) begin
      if (csm && overflow_A) csm_flag <= 1'b1;
      else if (cycles == 5'd31) csm_flag <= 1'b0;
    end
  end

  assign keyon = key_r[cycles] | csm_flag;
`else
  logic unused_csm;
  assign unused_csm = csm ^ overflow_A;
  assign keyon      = key_r[cycles];
`endif

  assign cur_op = cycles[4:3];
  assign cur_ch = cycles[2:0];
  assign zero   = (cycles == 5'd0);
  assign half   = (cycles[3:0] == 4'd0);

  assign rl  = rl_r[cur_ch];
  assign fb  = fb_r[cur_ch];
  assign con = con_r[cur_ch];
  assign kc  = kc_r[cur_ch];
  assign kf  = kf_r[cur_ch];
  assign pms = pms_r[cur_ch];
  assign ams = ams_r[cur_ch];

  assign dt1   = dt1_r[cycles];
  assign mul   = mul_r[cycles];
  assign tl    = tl_r[cycles];
  assign ks    = ks_r[cycles];
  assign ar    = ar_r[cycles];
  assign amsen = amsen_r[cycles];
  assign d1r   = d1r_r[cycles];
  assign dt2   = dt2_r[cycles];
  assign d2r   = d2r_r[cycles];
  assign d1l   = d1l_r[cycles];
  assign rr    = rr_r[cycles];

endmodule

// File: tb/tb_jt51_slot_regs.sv
// Scoreboard bench for jt51_slot_regs: directed phases then random writes, checked against a slot-level model.
module tb_jt51_slot_regs;

  logic       clk = 1'b0;
  logic       rst, cen, csm, overflow_A;
  logic [7:0] din;
  logic       up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l, up_keyon;
  logic [1:0] op;
  logic [2:0] ch;

  logic [4:0] cycles;
  logic [1:0] cur_op;
  logic [2:0] cur_ch;
  logic       zero, half;
  logic [1:0] rl;
  logic [2:0] fb, con;
  logic [6:0] kc;
  logic [5:0] kf;
  logic [2:0] pms;
  logic [1:0] ams;
  logic [2:0] dt1;
  logic [3:0] mul;
  logic [6:0] tl;
  logic [1:0] ks;
  logic [4:0] ar;
  logic       amsen;
  logic [4:0] d1r;
  logic [1:0] dt2;
  logic [4:0] d2r;
  logic [3:0] d1l, rr;
  logic       keyon;

  jt51_slot_regs dut (
    .clk(clk), .rst(rst), .cen(cen), .din(din),
    .up_rl(up_rl), .up_kc(up_kc), .up_kf(up_kf), .up_pms(up_pms),
    .up_dt1(up_dt1), .up_tl(up_tl), .up_ks(up_ks), .up_amsen(up_amsen),
    .up_dt2(up_dt2), .up_d1l(up_d1l), .up_keyon(up_keyon),
    .op(op), .ch(ch), .csm(csm), .overflow_A(overflow_A),
    .cycles(cycles), .cur_op(cur_op), .cur_ch(cur_ch), .zero(zero), .half(half),
    .rl(rl), .fb(fb), .con(con), .kc(kc), .kf(kf), .pms(pms), .ams(ams),
    .dt1(dt1), .mul(mul), .tl(tl), .ks(ks), .ar(ar), .amsen(amsen), .d1r(d1r),
    .dt2(dt2), .d2r(d2r), .d1l(d1l), .rr(rr), .keyon(keyon)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] s;
    logic [25:0] c;
    logic [41:0] o;
    logic        k;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference state: one entry per channel / per slot, slot = op*8 + ch
  int m_rl[8], m_fb[8], m_con[8], m_kc[8], m_kf[8], m_pms[8], m_ams[8];
  int m_dt1[32], m_mul[32], m_tl[32], m_ks[32], m_ar[32], m_amsen[32];
  int m_d1r[32], m_dt2[32], m_d2r[32], m_d1l[32], m_rr[32], m_key[32];
  int m_cyc = 0;
  int m_csm = 0;

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("slot",  {52'd0, cycles, cur_op, cur_ch, zero, half}, {52'd0, e.s});
      cmp("chan",  {38'd0, rl, fb, con, kc, kf, pms, ams}, {38'd0, e.c});
      cmp("oper",  {22'd0, dt1, mul, tl, ks, ar, amsen, d1r, dt2, d2r, d1l, rr}, {22'd0, e.o});
      cmp("keyon", {63'd0, keyon}, {63'd0, e.k});
    end
  end

  task automatic model_update();
    int s, c;
    int d;
    d = int'(din);
    c = int'(ch);
    s = int'(op) * 8 + c;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_rl[i] = 0; m_fb[i] = 0; m_con[i] = 0; m_kc[i] = 0; m_kf[i] = 0; m_pms[i] = 0; m_ams[i] = 0;
      end
      for (int i = 0; i < 32; i++) begin
        m_dt1[i] = 0; m_mul[i] = 0; m_tl[i] = 0; m_ks[i] = 0; m_ar[i] = 0; m_amsen[i] = 0;
        m_d1r[i] = 0; m_dt2[i] = 0; m_d2r[i] = 0; m_d1l[i] = 0; m_rr[i] = 0; m_key[i] = 0;
      end
      m_cyc = 0;
      m_csm = 0;
      return;
    end
    if (up_rl)    begin m_rl[c] = d / 64; m_fb[c] = (d / 8) % 8; m_con[c] = d % 8; end
    if (up_kc)    m_kc[c] = d % 128;
    if (up_kf)    m_kf[c] = d / 4;
    if (up_pms)   begin m_pms[c] = (d / 16) % 8; m_ams[c] = d % 4; end
    if (up_dt1)   begin m_dt1[s] = (d / 16) % 8; m_mul[s] = d % 16; end
    if (up_tl)    m_tl[s] = d % 128;
    if (up_ks)    begin m_ks[s] = d / 64; m_ar[s] = d % 32; end
    if (up_amsen) begin m_amsen[s] = d / 128; m_d1r[s] = d % 32; end
    if (up_dt2)   begin m_dt2[s] = d / 64; m_d2r[s] = d % 32; end
    if (up_d1l)   begin m_d1l[s] = d / 16; m_rr[s] = d % 16; end
    if (up_keyon) begin
      m_key[0 * 8 + d % 8] = (d / 8) % 2;   // M1
      m_key[2 * 8 + d % 8] = (d / 16) % 2;  // C1
      m_key[1 * 8 + d % 8] = (d / 32) % 2;  // M2
      m_key[3 * 8 + d % 8] = (d / 64) % 2;  // C2
    end
`ifdef JT51_CSM_EN
    if (cen) begin
      if (csm && overflow_A) m_csm = 1;
      else if (m_cyc == 31) m_csm = 0;
    end
`endif
    if (cen) m_cyc = (m_cyc + 1) % 32;
  endtask

  function automatic exp_t expected();
    exp_t e;
    int h, y;
    y = m_cyc;
    h = y % 8;
    e.s = {5'(y), 2'(y / 8), 3'(h), (y == 0), (y % 16 == 0)};
    e.c = {2'(m_rl[h]), 3'(m_fb[h]), 3'(m_con[h]), 7'(m_kc[h]), 6'(m_kf[h]), 3'(m_pms[h]), 2'(m_ams[h])};
    e.o = {3'(m_dt1[y]), 4'(m_mul[y]), 7'(m_tl[y]), 2'(m_ks[y]), 5'(m_ar[y]), 1'(m_amsen[y]),
           5'(m_d1r[y]), 2'(m_dt2[y]), 5'(m_d2r[y]), 4'(m_d1l[y]), 4'(m_rr[y])};
    e.k = (m_key[y] != 0) || (m_csm != 0);
    return e;
  endfunction

  task automatic clear_strobes();
    {up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l, up_keyon} = '0;
    csm = 1'b0;
    overflow_A = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
    q.push_back(expected());
    clear_strobes();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cen = 1'b0; din = 8'h00; op = 2'd0; ch = 3'd0;
    clear_strobes();
    tick();
    up_tl = 1'b1; op = 2'd0; ch = 3'd0; din = 8'h55; cen = 1'b1;
    tick();
    rst = 1'b0; cen = 1'b0;
    tick();

    cen = 1'b1;
    repeat (40) tick();

    up_tl = 1'b1; op = 2'd2; ch = 3'd5; din = 8'h7F;
    tick();
    repeat (40) tick();

    up_keyon = 1'b1; din = 8'h7B;
    tick();
    repeat (32) tick();
    up_keyon = 1'b1; din = 8'h03;
    tick();
    repeat (32) tick();

    up_rl = 1'b1; ch = 3'd2; din = 8'hD5;
    tick();
    repeat (32) tick();

    while (m_cyc != 0) tick();
    csm = 1'b1; overflow_A = 1'b1;
    tick();
    repeat (40) tick();

    cen = 1'b0;
    repeat (4) tick();
    up_kc = 1'b1; ch = 3'(m_cyc % 8); din = 8'h6A;
    up_dt1 = 1'b1; op = 2'(m_cyc / 8); 
    tick();
    repeat (5) tick();
    cen = 1'b1;
    repeat (32) tick();

    for (int n = 0; n < 1500; n++) begin
      cen        = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 399) == 0);
      din        = 8'($urandom);
      op         = 2'($urandom);
      ch         = 3'($urandom);
      up_rl      = ($urandom_range(0, 7) == 0);
      up_kc      = ($urandom_range(0, 7) == 0);
      up_kf      = ($urandom_range(0, 7) == 0);
      up_pms     = ($urandom_range(0, 7) == 0);
      up_dt1     = ($urandom_range(0, 7) == 0);
      up_tl      = ($urandom_range(0, 7) == 0);
      up_ks      = ($urandom_range(0, 7) == 0);
      up_amsen   = ($urandom_range(0, 7) == 0);
      up_dt2     = ($urandom_range(0, 7) == 0);
      up_d1l     = ($urandom_range(0, 7) == 0);
      up_keyon   = ($urandom_range(0, 7) == 0);
      csm        = ($urandom_range(0, 39) == 0);
      overflow_A = csm && ($urandom_range(0, 1) == 0);
      tick();
      rst = 1'b0;
    end

    cen = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    @(negedge clk);
    cmp("drain", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
